// File: rtl/mem_access_unit.sv
// Memory-stage data-bus access unit: turns a decoded load/store into one dbus
// transaction, stalls the pipeline until data_ok, and returns extended load data.
`timescale 1ns/1ps

package mem_access_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | no transaction; an aligned memory op is latched and issued from here
// BUSY  | dreq.valid high, waiting for data_ok
// DONE  | result presented for one cycle on out_valid/out_rdata
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        stall,
  output logic        out_valid,
  output logic [63:0] out_rdata,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic        mem_op, aligned, issue;
  logic [7:0]  size_mask;
  logic [63:0] raw, load_ext;

  logic [63:0] req_addr;
  msize_t      req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic [2:0]  req_funct3;
  logic        req_load;
  logic [63:0] rdata_q;

  assign mem_op = in_valid & (in_is_load | in_is_store);
  assign issue  = (state == IDLE) & mem_op & aligned;

  always_comb begin
    aligned   = 1'b1;
    size_mask = 8'h01;
    case (in_funct3[1:0])
      2'd0: begin aligned = 1'b1;                size_mask = 8'h01; end
      2'd1: begin aligned = ~in_addr[0];         size_mask = 8'h03; end
      2'd2: begin aligned = in_addr[1:0] == 2'd0; size_mask = 8'h0F; end
      default: begin aligned = in_addr[2:0] == 3'd0; size_mask = 8'hFF; end
    endcase
  end

  // Extraction runs off the latched request so it is stable for the whole BUSY phase.
  always_comb begin
    raw      = dresp.data >> {req_addr[2:0], 3'b000};
    load_ext = raw;
    case (req_size)
      MSIZE1:  load_ext = req_funct3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      MSIZE2:  load_ext = req_funct3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      MSIZE4:  load_ext = req_funct3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_size   <= MSIZE1;
      req_strobe <= '0;
      req_data   <= '0;
      req_funct3 <= '0;
      req_load   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (issue) begin
        req_addr   <= in_addr;
        req_size   <= msize_t'({1'b0, in_funct3[1:0]});
        req_strobe <= in_is_load ? 8'h00 : size_mask << in_addr[2:0];
        req_data   <= in_is_load ? 64'd0 : in_wdata << {in_addr[2:0], 3'b000};
        req_funct3 <= in_funct3;
        req_load   <= in_is_load;
      end
      if (state == BUSY && dresp.data_ok)
        rdata_q <= req_load ? load_ext : 64'd0;
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    misalign = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            stall    = 1'b1;
            state_nx = BUSY;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dresp.data_ok) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign dreq.valid  = (state == BUSY);
  assign dreq.addr   = req_addr;
  assign dreq.size   = req_size;
  assign dreq.strobe = req_strobe;
  assign dreq.data   = req_data;
  assign out_valid   = (state == DONE);
  assign out_rdata   = rdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-bus access unit of the 5-stage pipeline, placed between the EX/MEM pipeline register and the MEM/WB register. It turns a decoded load or store into a single `dbus_req_t` transaction. It holds the pipeline with `stall` until the bus returns `data_ok`, then delivers lane-aligned, sign- or zero-extended load data for writeback. Non-memory instructions pass through with no bus activity and no stall.

## Interface
Parameters:
- none (XLEN fixed at 64, bus data 64 bit)

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  instruction present in MEM this cycle (from `dataE`)
- `in_is_load`  in  1  instruction is LB/LH/LW/LD/LBU/LHU/LWU
- `in_is_store`  in  1  instruction is SB/SH/SW/SD
- `in_funct3`  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- `in_addr`  in  64  effective address (ALU result)
- `in_wdata`  in  64  store data (rs2 value, unshifted)
- `dreq`  out  `dbus_req_t`  fields: `valid`, `addr[63:0]`, `size` (msize_t: 0=1B, 1=2B, 2=4B, 3=8B), `strobe[7:0]`, `data[63:0]`
- `dresp`  in  `dbus_resp_t`  fields used: `data_ok`, `data[63:0]`
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB
- `out_valid`  out  1  load/store completed this cycle
- `out_rdata`  out  64  extended load result (0 for stores)
- `misalign`  out  1  access was misaligned and not issued

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_valid & (in_is_load | in_is_store)` and aligned → latch the request fields and go to BUSY.
  - Same condition but misaligned → stay in IDLE, no request.
  - Otherwise → stay in IDLE.
- BUSY:
  - `dreq.valid=1`, with all request fields driven from registers.
  - On `dresp.data_ok` → latch `dresp.data`, go to DONE.
  - Otherwise → stay in BUSY, request fields held stable.
- DONE: `out_valid=1`, then go to IDLE unconditionally.
- Alignment rules:
  - Halfword requires `addr[0]==0`.
  - Word requires `addr[1:0]==0`.
  - Doubleword requires `addr[2:0]==0`.
  - Byte is always aligned.
- Request encoding:
  - `dreq.addr = in_addr` (full address).
  - `size = funct3[1:0]`.
  - Store `strobe` = {1,3,F,FF}[size] << `addr[2:0]`.
  - Store `data` = `in_wdata << (8*addr[2:0])`.
  - Loads: `strobe = 0`.
- Load result:
  - `raw = resp >> (8*addr[2:0])`.
  - Truncate to the access size.
  - Sign-extend when `funct3[2]==0`, zero-extend otherwise.
- `stall` (combinational):
  - 1 in IDLE when an aligned memory op is present.
  - 1 in BUSY.
  - 0 in DONE and in all other cases.
- `misalign`: combinational, 1 in IDLE when a memory op is present and misaligned. `stall` stays 0 in this case.
- Non-memory instructions with `in_valid`: `stall=0`, `out_valid=0`, no bus traffic.

## Timing
- Reset values:
  - State = IDLE.
  - `dreq.valid=0`; `dreq.addr`/`size`/`strobe`/`data` = 0.
  - `out_valid=0`, `out_rdata=0`.
  - `stall=0` unless an aligned memory op is present.
  - `misalign=0` unless a misaligned memory op is present.
- Latency: issue cycle (IDLE, stall) + N bus cycles (BUSY) + DONE. With `data_ok` arriving in the first BUSY cycle, the op spends 3 cycles in MEM and `stall` is high for 2.
- `dreq.valid` is registered and never asserted in IDLE or DONE, so there is at most one outstanding transaction.
- `dreq.valid` stays high until `data_ok`, and no field changes while it is high.
- `data_ok` outside BUSY is ignored.
- `out_rdata` and `out_valid` come from registers and are valid only in the DONE cycle. `out_rdata` holds its value afterwards, but consumers gate on `out_valid`.
- In DONE `stall=0`, so EX/MEM loads the next instruction at that clock edge. The same instruction is never reissued.
- Back-to-back memory ops: DONE → IDLE, then the next op is issued in the following cycle (one IDLE cycle minimum between transactions).
- Reset asserted mid-BUSY: immediate return to IDLE with `dreq.valid=0`. A `data_ok` that arrives later is ignored.

## Test plan
- LD at addr 0x80001000, `data_ok` in first BUSY cycle, resp 0x1122334455667788 → `dreq.valid` 1 cycle with size=3, strobe=0; `out_valid` on cycle 3 with `out_rdata`=0x1122334455667788; `stall` high for exactly 2 cycles.
- LB at addr 0x...1003, resp 0x00000000_80FF0000 → byte 0x80 → `out_rdata`=0xFFFFFFFFFFFFFF80. Same access as LBU → 0x80.
- SH at addr 0x...1006, wdata 0xABCD → size=1, strobe=0xC0, data=0xABCD000000000000; `out_rdata`=0.
- `data_ok` withheld for 5 cycles → `dreq` stable for 5 cycles, `stall` high for 6 cycles, single `out_valid` pulse.
- LW at addr 0x...1002 → `misalign`=1, `stall`=0, `dreq.valid` never asserted.
- Reset pulse in BUSY, then stray `data_ok` → `dreq.valid`=0 immediately, state IDLE, no `out_valid`.
